// File: rtl/axi4_lite_master_router_if.sv
// AXI4-Lite multi-slave master bus bundle.
// Each channel field is a flattened vector with one slice per slave.
interface axi4_lite_master_router_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4
);
  localparam int N  = NUM_SLAVES;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  logic [N*AW-1:0]     m_awaddr;
  logic [N-1:0]        m_awvalid;
  logic [N-1:0]        m_awready;
  logic [N*DW-1:0]     m_wdata;
  logic [N*DW/8-1:0]   m_wstrb;
  logic [N-1:0]        m_wvalid;
  logic [N-1:0]        m_wready;
  logic [2*N-1:0]      m_bresp;
  logic [N-1:0]        m_bvalid;
  logic [N-1:0]        m_bready;
  logic [N*AW-1:0]     m_araddr;
  logic [N-1:0]        m_arvalid;
  logic [N-1:0]        m_arready;
  logic [N*DW-1:0]     m_rdata;
  logic [2*N-1:0]      m_rresp;
  logic [N-1:0]        m_rvalid;
  logic [N-1:0]        m_rready;

  modport master (
    output m_awaddr, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wvalid,
    input  m_wready,
    input  m_bresp, m_bvalid,
    output m_bready,
    output m_araddr, m_arvalid,
    input  m_arready,
    input  m_rdata, m_rresp, m_rvalid,
    output m_rready
  );

  modport slave (
    input  m_awaddr, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wvalid,
    output m_wready,
    output m_bresp, m_bvalid,
    input  m_bready,
    input  m_araddr, m_arvalid,
    output m_arready,
    output m_rdata, m_rresp, m_rvalid,
    input  m_rready
  );
endinterface

// File: rtl/axi4_lite_master_router.sv
// AXI4-Lite master router: start/busy requests from the MEM stage are
// decoded onto one of NUM_SLAVES channels, with independent read/write FSMs.
module axi4_lite_master_router #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
    {4{32'hF000_0000}},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    write_start,
  input  logic [ADDR_WIDTH-1:0]   write_addr,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] write_strobe,
  output logic                    write_busy,
  output logic [1:0]              write_resp,
  input  logic                    read_start,
  input  logic [ADDR_WIDTH-1:0]   read_addr,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    read_busy,
  output logic [1:0]              read_resp,
  output logic                    timeout_flag,
  axi4_lite_master_router_if.master m
);
  localparam int N  = NUM_SLAVES;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wst_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rst_t;

  wst_t r_ws, w_ws_n;
  rst_t r_rs, w_rs_n;

  logic [AW-1:0] r_waddr, r_raddr;
  logic [DW-1:0] r_wdata, r_rdata;
  logic [SW-1:0] r_wstrb;
  logic [N-1:0]  r_wsel, r_rsel;
  logic          r_aw_done, r_w_done;
  logic [15:0]   r_wcnt, r_rcnt;
  logic [1:0]    r_wresp, r_rresp;
  logic          r_to;

  logic [N-1:0]  w_whits, w_rhits, w_wsel, w_rsel;
  logic          w_awv, w_wv;
  logic          w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic [1:0]    w_bresp, w_rresp_in;
  logic [DW-1:0] w_rdata_in;
  logic          w_wto, w_rto;
  logic [1:0]    w_wresp_n, w_rresp_n;
  logic [DW-1:0] w_rdata_n;
  logic          w_wto_ev, w_rto_ev;
  logic          w_wacc, w_racc;

  // Lowest-index window wins on overlap: isolate the lowest set hit bit.
  always_comb begin
    w_whits = '0;
    w_rhits = '0;
    for (int i = 0; i < N; i++) begin
      w_whits[i] = (write_addr & SLAVE_MASK[i*AW +: AW])
                   == SLAVE_BASE[i*AW +: AW];
      w_rhits[i] = (read_addr & SLAVE_MASK[i*AW +: AW])
                   == SLAVE_BASE[i*AW +: AW];
    end
  end

  assign w_wsel = w_whits & (~w_whits + N'(1));
  assign w_rsel = w_rhits & (~w_rhits + N'(1));

  always_comb begin
    w_bresp    = '0;
    w_rresp_in = '0;
    w_rdata_in = '0;
    for (int i = 0; i < N; i++) begin
      if (r_wsel[i]) w_bresp = m.m_bresp[2*i +: 2];
      if (r_rsel[i]) begin
        w_rresp_in = m.m_rresp[2*i +: 2];
        w_rdata_in = m.m_rdata[i*DW +: DW];
      end
    end
  end

  assign w_wacc = (r_ws == W_IDLE) && write_start;
  assign w_racc = (r_rs == R_IDLE) && read_start;

  assign w_awv   = (r_ws == W_ADDR) && !r_aw_done;
  assign w_wv    = (r_ws == W_ADDR) && !r_w_done;
  assign w_aw_hs = w_awv && |(r_wsel & m.m_awready);
  assign w_w_hs  = w_wv && |(r_wsel & m.m_wready);
  assign w_b_hs  = (r_ws == W_RESP) && |(r_wsel & m.m_bvalid);
  assign w_ar_hs = (r_rs == R_ADDR) && |(r_rsel & m.m_arready);
  assign w_r_hs  = (r_rs == R_DATA) && |(r_rsel & m.m_rvalid);
  assign w_wto   = r_wcnt >= TO_LAST;
  assign w_rto   = r_rcnt >= TO_LAST;

  assign m.m_awaddr  = {N{r_waddr}};
  assign m.m_wdata   = {N{r_wdata}};
  assign m.m_wstrb   = {N{r_wstrb}};
  assign m.m_awvalid = w_awv ? r_wsel : '0;
  assign m.m_wvalid  = w_wv ? r_wsel : '0;
  assign m.m_bready  = (r_ws == W_RESP) ? r_wsel : '0;
  assign m.m_araddr  = {N{r_raddr}};
  assign m.m_arvalid = (r_rs == R_ADDR) ? r_rsel : '0;
  assign m.m_rready  = (r_rs == R_DATA) ? r_rsel : '0;

  always_comb begin
    w_ws_n    = r_ws;
    w_wresp_n = r_wresp;
    w_wto_ev  = 1'b0;
    unique case (r_ws)
      W_IDLE: if (write_start) w_ws_n = W_ADDR;
      W_ADDR: begin
        if (!(|r_wsel)) begin
          w_ws_n    = W_IDLE;
          w_wresp_n = 2'b11;
        end else if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
          w_ws_n = W_RESP;
        end else if (w_wto) begin
          w_ws_n    = W_IDLE;
          w_wresp_n = 2'b10;
          w_wto_ev  = 1'b1;
        end
      end
      W_RESP: begin
        if (w_b_hs) begin
          w_ws_n    = W_IDLE;
          w_wresp_n = w_bresp;
        end else if (w_wto) begin
          w_ws_n    = W_IDLE;
          w_wresp_n = 2'b10;
          w_wto_ev  = 1'b1;
        end
      end
      default: w_ws_n = W_IDLE;
    endcase
  end

  always_comb begin
    w_rs_n    = r_rs;
    w_rresp_n = r_rresp;
    w_rdata_n = r_rdata;
    w_rto_ev  = 1'b0;
    unique case (r_rs)
      R_IDLE: if (read_start) w_rs_n = R_ADDR;
      R_ADDR: begin
        if (!(|r_rsel)) begin
          w_rs_n    = R_IDLE;
          w_rresp_n = 2'b11;
          w_rdata_n = '0;
        end else if (w_ar_hs) begin
          w_rs_n = R_DATA;
        end else if (w_rto) begin
          w_rs_n    = R_IDLE;
          w_rresp_n = 2'b10;
          w_rdata_n = '0;
          w_rto_ev  = 1'b1;
        end
      end
      R_DATA: begin
        if (w_r_hs) begin
          w_rs_n    = R_IDLE;
          w_rresp_n = w_rresp_in;
          w_rdata_n = w_rdata_in;
        end else if (w_rto) begin
          w_rs_n    = R_IDLE;
          w_rresp_n = 2'b10;
          w_rdata_n = '0;
          w_rto_ev  = 1'b1;
        end
      end
      default: w_rs_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ws <= W_IDLE;
      r_rs <= R_IDLE;
    end else begin
      r_ws <= w_ws_n;
      r_rs <= w_rs_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_wsel    <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_wcnt    <= '0;
      r_wresp   <= 2'b00;
    end else begin
      r_wresp <= w_wresp_n;
      if (w_wacc) begin
        r_waddr   <= write_addr;
        r_wdata   <= write_data;
        r_wstrb   <= write_strobe;
        r_wsel    <= w_wsel;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_wcnt    <= '0;
      end else if (r_ws != W_IDLE) begin
        if (r_wcnt != 16'hFFFF) r_wcnt <= r_wcnt + 16'd1;
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs) r_w_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_raddr <= '0;
      r_rsel  <= '0;
      r_rcnt  <= '0;
      r_rresp <= 2'b00;
      r_rdata <= '0;
      r_to    <= 1'b0;
    end else begin
      r_rresp <= w_rresp_n;
      r_rdata <= w_rdata_n;
      r_to    <= r_to | w_wto_ev | w_rto_ev;
      if (w_racc) begin
        r_raddr <= read_addr;
        r_rsel  <= w_rsel;
        r_rcnt  <= '0;
      end else if (r_rs != R_IDLE) begin
        if (r_rcnt != 16'hFFFF) r_rcnt <= r_rcnt + 16'd1;
      end
    end
  end

  assign write_busy   = r_ws != W_IDLE;
  assign read_busy    = r_rs != R_IDLE;
  assign write_resp   = r_wresp;
  assign read_resp    = r_rresp;
  assign read_data    = r_rdata;
  assign timeout_flag = r_to;
endmodule
